// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES round datapath: accepts one block,
// steps the round-key index through NUM_ROUNDS rounds and hands the result off.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS   = 10,
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic       opt_mode,
  input  logic       key_ready,
  input  logic       abort,
  output logic       load_state,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       last_round,
  output logic       mode_lat,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] NR_L     = 4'(NUM_ROUNDS);
  localparam logic [2:0] SUB_LAST = 3'(ROUND_CYCLES - 1);

  state_t     state_q;
  logic [3:0] rnd_q;
  logic [2:0] sub_q;
  logic       mode_q;
  logic       acc_s;

  // Output decode; blk_ready is gated by n_rst so every output reads 0 in reset.
  always_comb begin
    blk_ready  = 1'b0;
    load_state = 1'b0;
    round_en   = 1'b0;
    round_idx  = 4'd0;
    last_round = 1'b0;
    out_valid  = 1'b0;
    acc_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        blk_ready = n_rst & key_ready & ~abort;
      end
      S_ROUND: begin
        round_en   = key_ready & (sub_q == SUB_LAST);
        last_round = (rnd_q == NR_L);
        round_idx  = mode_q ? (NR_L - rnd_q) : rnd_q;
      end
      S_DONE: begin
        out_valid = 1'b1;
        blk_ready = n_rst & out_ready & key_ready & ~abort;
      end
      default: begin
        blk_ready = 1'b0;
      end
    endcase
    acc_s = blk_valid & blk_ready;
    // A newly accepted block overrides the index with its initial-key slot.
    if (acc_s) begin
      load_state = 1'b1;
      round_idx  = opt_mode ? NR_L : 4'd0;
    end else begin
      load_state = 1'b0;
    end
  end

  // Sequencer state, round counter and sub-cycle counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      sub_q   <= 3'd0;
      mode_q  <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      sub_q   <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc_s) begin
            mode_q  <= opt_mode;
            rnd_q   <= 4'd1;
            sub_q   <= 3'd0;
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          // Missing round keys freeze both counters.
          if (key_ready) begin
            if (sub_q == SUB_LAST) begin
              sub_q <= 3'd0;
              if (rnd_q == NR_L) begin
                rnd_q   <= 4'd0;
                state_q <= S_DONE;
              end else begin
                rnd_q <= rnd_q + 4'd1;
              end
            end else begin
              sub_q <= sub_q + 3'd1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            if (acc_s) begin
              mode_q  <= opt_mode;
              rnd_q   <= 4'd1;
              sub_q   <= 3'd0;
              state_q <= S_ROUND;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          rnd_q   <= 4'd0;
          sub_q   <= 3'd0;
        end
      endcase
    end
  end

  assign mode_lat = mode_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (1 and 3 cycles per round) driven
// by shared stimulus and checked against a work-count model of the round schedule.
module tb_aes_round_sequencer;

  localparam int NR = 10;

  logic clk, n_rst, blk_valid, opt_mode, key_ready, abort, out_ready;
  logic a_blk_ready, a_load_state, a_round_en, a_last_round, a_mode_lat, a_out_valid, a_busy;
  logic b_blk_ready, b_load_state, b_round_en, b_last_round, b_mode_lat, b_out_valid, b_busy;
  logic [3:0] a_round_idx, b_round_idx;
  logic [10:0] dut_vec [2];

  int n_pass, n_total;
  int m_phase [2];   // 0 idle, 1 computing, 2 holding result
  int m_work [2];    // active (key-ready) cycles spent on the current block
  logic m_dec [2];
  int rc_of [2];

  aes_round_sequencer #(.NUM_ROUNDS(NR), .ROUND_CYCLES(1)) u_a (
    .clk(clk), .n_rst(n_rst), .blk_valid(blk_valid), .blk_ready(a_blk_ready),
    .opt_mode(opt_mode), .key_ready(key_ready), .abort(abort),
    .load_state(a_load_state), .round_en(a_round_en), .round_idx(a_round_idx),
    .last_round(a_last_round), .mode_lat(a_mode_lat), .out_valid(a_out_valid),
    .out_ready(out_ready), .busy(a_busy));

  aes_round_sequencer #(.NUM_ROUNDS(NR), .ROUND_CYCLES(3)) u_b (
    .clk(clk), .n_rst(n_rst), .blk_valid(blk_valid), .blk_ready(b_blk_ready),
    .opt_mode(opt_mode), .key_ready(key_ready), .abort(abort),
    .load_state(b_load_state), .round_en(b_round_en), .round_idx(b_round_idx),
    .last_round(b_last_round), .mode_lat(b_mode_lat), .out_valid(b_out_valid),
    .out_ready(out_ready), .busy(b_busy));

  assign dut_vec[0] = {a_blk_ready, a_load_state, a_round_en, a_round_idx, a_last_round, a_mode_lat, a_out_valid, a_busy};
  assign dut_vec[1] = {b_blk_ready, b_load_state, b_round_en, b_round_idx, b_last_round, b_mode_lat, b_out_valid, b_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {blk_ready, load_state, round_en, round_idx, last_round, mode_lat, out_valid, busy}
  function automatic logic [10:0] model_out(input int k);
    int rc, rnd;
    logic br, ld, ren, lr;
    logic [3:0] idx;
    rc = rc_of[k]; br = 1'b0; ld = 1'b0; ren = 1'b0; lr = 1'b0; idx = 4'd0;
    if (!n_rst) return 11'd0;
    if (!abort && key_ready && (m_phase[k] == 0 || (m_phase[k] == 2 && out_ready))) br = 1'b1;
    if (m_phase[k] == 1) begin
      rnd = m_work[k] / rc + 1;
      ren = key_ready && ((m_work[k] % rc) == rc - 1);
      lr  = (rnd == NR);
      idx = m_dec[k] ? 4'(NR - rnd) : 4'(rnd);
    end
    if (blk_valid && br) begin
      ld  = 1'b1;
      idx = opt_mode ? 4'(NR) : 4'd0;
    end
    return {br, ld, ren, idx, lr, m_dec[k], m_phase[k] == 2, m_phase[k] != 0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_work[k] = 0; m_dec[k] = 1'b0;
    end
  endtask

  task automatic model_commit();
    logic [10:0] o;
    logic acc;
    for (int k = 0; k < 2; k++) begin
      o = model_out(k);
      acc = blk_valid && o[10];
      if (abort) begin
        m_phase[k] = 0; m_work[k] = 0;
      end else if (m_phase[k] == 0) begin
        if (acc) begin m_phase[k] = 1; m_work[k] = 0; m_dec[k] = opt_mode; end
      end else if (m_phase[k] == 1) begin
        if (key_ready) begin
          m_work[k]++;
          if (m_work[k] == NR * rc_of[k]) m_phase[k] = 2;
        end
      end else if (out_ready) begin
        if (acc) begin m_phase[k] = 1; m_work[k] = 0; m_dec[k] = opt_mode; end
        else m_phase[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0; blk_valid = 1'b0; opt_mode = 1'b0; key_ready = 1'b1; abort = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; blk_valid = 1'b1; opt_mode = 1'b1; key_ready = 1'b1; abort = 1'b0; out_ready = 1'b1;
    model_reset();
    #1;
    n_total++;
    if ({dut_vec[1], dut_vec[0]} !== 22'd0) $display("FAIL reset_outputs got=%b want=0", {dut_vec[1], dut_vec[0]});
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_total++;
    if ({a_blk_ready, a_busy, a_round_idx, a_mode_lat} !== {1'b1, 1'b0, 4'd0, 1'b0})
      $display("FAIL reset_idle got=%b want=%b", {a_blk_ready, a_busy, a_round_idx, a_mode_lat}, {1'b1, 1'b0, 4'd0, 1'b0});
    else n_pass++;
    tick();
  endtask

  task automatic test_round_sequence(input bit dec);
    logic [10:0] exp;
    logic [3:0] lr_idx, want_idx;
    int ren_cnt, first_ov, lr_cnt, lr_cyc, idx_bad;
    do_reset();
    ren_cnt = 0; first_ov = -1; lr_cnt = 0; lr_cyc = -1; idx_bad = 0; lr_idx = 4'hf;
    blk_valid = 1'b1; opt_mode = dec; key_ready = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      exp = model_out(0);
      n_total++;
      if (dut_vec[0] !== exp) $display("FAIL seq_dec%0d_cyc%0d got=%b want=%b", dec, c, dut_vec[0], exp);
      else n_pass++;
      if (c == 0) begin
        n_total++;
        if ({a_load_state, a_round_idx} !== {1'b1, (dec ? 4'd10 : 4'd0)})
          $display("FAIL seq_load got=%b want=%b", {a_load_state, a_round_idx}, {1'b1, (dec ? 4'd10 : 4'd0)});
        else n_pass++;
      end
      if (a_round_en) begin
        ren_cnt++;
        want_idx = dec ? 4'(NR - c) : 4'(c);
        if (a_round_idx !== want_idx) idx_bad++;
      end
      if (a_last_round) begin lr_cnt++; lr_cyc = c; lr_idx = a_round_idx; end
      if (a_out_valid && first_ov < 0) first_ov = c;
      tick();
      blk_valid = 1'b0;
    end
    n_total++;
    if (ren_cnt != NR || idx_bad != 0) $display("FAIL seq_rounds got=%0d/%0d bad want=%0d/0 bad", ren_cnt, idx_bad, NR);
    else n_pass++;
    n_total++;
    if (lr_cnt != 1 || lr_cyc != 10 || lr_idx !== (dec ? 4'd0 : 4'd10))
      $display("FAIL seq_last got=cnt%0d cyc%0d idx%0d want=cnt1 cyc10 idx%0d", lr_cnt, lr_cyc, lr_idx, dec ? 0 : 10);
    else n_pass++;
    n_total++;
    if (first_ov != 11 || a_mode_lat !== dec) $display("FAIL seq_outvalid got=%0d ml%b want=11 ml%b", first_ov, a_mode_lat, dec);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [10:0] exp;
    do_reset();
    opt_mode = 1'b0; key_ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      blk_valid = (c == 0 || c == 16);
      out_ready = (c >= 16);
      @(negedge clk);
      exp = model_out(0);
      n_total++;
      if (dut_vec[0] !== exp) $display("FAIL bp_cyc%0d got=%b want=%b", c, dut_vec[0], exp);
      else n_pass++;
      if (c >= 11 && c <= 15) begin
        n_total++;
        if ({a_out_valid, a_blk_ready} !== 2'b10) $display("FAIL bp_hold_cyc%0d got=%b want=10", c, {a_out_valid, a_blk_ready});
        else n_pass++;
      end
      if (c == 16) begin
        n_total++;
        if ({a_load_state, a_blk_ready, a_out_valid} !== 3'b111) $display("FAIL bp_b2b_load got=%b want=111", {a_load_state, a_blk_ready, a_out_valid});
        else n_pass++;
      end
      if (c == 17) begin
        n_total++;
        if ({a_busy, a_out_valid, a_round_en, a_round_idx} !== {3'b101, 4'd1})
          $display("FAIL bp_b2b_round got=%b want=%b", {a_busy, a_out_valid, a_round_en, a_round_idx}, {3'b101, 4'd1});
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_key_stall();
    logic [10:0] exp;
    int first_ov, ren_cnt;
    do_reset();
    first_ov = -1; ren_cnt = 0; opt_mode = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      blk_valid = (c == 0);
      key_ready = !(c >= 4 && c <= 6);
      @(negedge clk);
      exp = model_out(0);
      n_total++;
      if (dut_vec[0] !== exp) $display("FAIL stall_cyc%0d got=%b want=%b", c, dut_vec[0], exp);
      else n_pass++;
      if (c >= 4 && c <= 6) begin
        n_total++;
        if ({a_round_en, a_round_idx, a_busy} !== {1'b0, 4'd4, 1'b1})
          $display("FAIL stall_hold_cyc%0d got=%b want=%b", c, {a_round_en, a_round_idx, a_busy}, {1'b0, 4'd4, 1'b1});
        else n_pass++;
      end
      if (a_round_en) ren_cnt++;
      if (a_out_valid && first_ov < 0) first_ov = c;
      tick();
    end
    key_ready = 1'b1;
    n_total++;
    if (first_ov != 14 || ren_cnt != NR) $display("FAIL stall_latency got=%0d/%0d want=14/%0d", first_ov, ren_cnt, NR);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [10:0] exp;
    int ov_seen;
    do_reset();
    ov_seen = 0; opt_mode = 1'b0; key_ready = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 21; c++) begin
      blk_valid = (c == 0);
      abort = (c == 6);
      @(negedge clk);
      exp = model_out(0);
      n_total++;
      if (dut_vec[0] !== exp) $display("FAIL abort_cyc%0d got=%b want=%b", c, dut_vec[0], exp);
      else n_pass++;
      if (c == 6) begin
        n_total++;
        if ({a_round_en, a_round_idx, a_busy} !== {1'b1, 4'd6, 1'b1})
          $display("FAIL abort_same_cycle got=%b want=%b", {a_round_en, a_round_idx, a_busy}, {1'b1, 4'd6, 1'b1});
        else n_pass++;
      end
      if (c == 7) begin
        n_total++;
        if ({a_busy, b_busy} !== 2'b00) $display("FAIL abort_idle got=%b want=00", {a_busy, b_busy});
        else n_pass++;
      end
      if (a_out_valid || b_out_valid) ov_seen++;
      tick();
    end
    n_total++;
    if (ov_seen != 0) $display("FAIL abort_no_output got=%0d want=0", ov_seen);
    else n_pass++;
    blk_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    n_total++;
    if ({a_blk_ready, a_load_state, b_blk_ready, b_load_state} !== 4'b0000)
      $display("FAIL abort_idle_accept got=%b want=0000", {a_blk_ready, a_load_state, b_blk_ready, b_load_state});
    else n_pass++;
    tick();
    blk_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_total++;
    if ({a_busy, b_busy} !== 2'b00 || dut_vec[0] !== model_out(0))
      $display("FAIL abort_after got=%b want=%b", dut_vec[0], model_out(0));
    else n_pass++;
    tick();
  endtask

  task automatic test_rc3();
    logic [10:0] exp;
    int first_ov, ren_cnt, bad;
    do_reset();
    first_ov = -1; ren_cnt = 0; bad = 0; opt_mode = 1'b0; key_ready = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 33; c++) begin
      blk_valid = (c == 0);
      @(negedge clk);
      exp = model_out(1);
      n_total++;
      if (dut_vec[1] !== exp) $display("FAIL rc3_cyc%0d got=%b want=%b", c, dut_vec[1], exp);
      else n_pass++;
      if (b_round_en) begin
        ren_cnt++;
        if ((c % 3) != 0 || b_round_idx !== 4'(c / 3)) bad++;
      end
      if (b_out_valid && first_ov < 0) first_ov = c;
      tick();
    end
    n_total++;
    if (ren_cnt != NR || bad != 0 || first_ov != 31)
      $display("FAIL rc3_schedule got=%0d/%0d/%0d want=%0d/0/31", ren_cnt, bad, first_ov, NR);
    else n_pass++;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      blk_valid = (c == 0);
      @(negedge clk);
      exp = model_out(1);
      n_total++;
      if (dut_vec[1] !== exp) $display("FAIL rc3b_cyc%0d got=%b want=%b", c, dut_vec[1], exp);
      else n_pass++;
      tick();
    end
    blk_valid = 1'b0;
    n_rst = 1'b0;
    model_reset();
    #1;
    n_total++;
    if ({dut_vec[1], dut_vec[0]} !== 22'd0) $display("FAIL rc3_midreset got=%b want=0", {dut_vec[1], dut_vec[0]});
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    @(negedge clk);
    n_total++;
    if (b_busy !== 1'b0 || dut_vec[1] !== model_out(1)) $display("FAIL rc3_release got=%b want=%b", dut_vec[1], model_out(1));
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [10:0] exp0, exp1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      blk_valid = 1'($urandom_range(0, 1));
      opt_mode  = 1'($urandom_range(0, 1));
      key_ready = ($urandom_range(0, 7) != 0);
      out_ready = 1'($urandom_range(0, 1));
      abort     = ($urandom_range(0, 40) == 0);
      @(negedge clk);
      exp0 = model_out(0);
      exp1 = model_out(1);
      n_total++;
      if (dut_vec[0] !== exp0 || dut_vec[1] !== exp1)
        $display("FAIL rand_cyc%0d got=%b_%b want=%b_%b", c, dut_vec[0], dut_vec[1], exp0, exp1);
      else n_pass++;
      tick();
    end
    abort = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rc_of[0] = 1; rc_of[1] = 3;
    test_reset();
    test_round_sequence(1'b0);
    test_round_sequence(1'b1);
    test_backpressure();
    test_key_stall();
    test_abort();
    test_rc3();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
